// File: rtl/weight_gen_pkg.sv
// Shared types and helpers for the constant-weight word generator.
package weight_gen_pkg;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  // Widest word the trailing-zero helper supports; callers zero-extend into it.
  localparam int MAX_W = 64;

  // Trailing-zero count over the low w bits of x; returns w when those bits are all zero.
  function automatic int ctz_w(input logic [MAX_W-1:0] x, input int w);
    int n;
    n = w;
    for (int i = MAX_W - 1; i >= 0; i--) begin
      if (i < w && x[i]) n = i;
    end
    return n;
  endfunction

endpackage

// File: rtl/weight_gen_next.sv
// Combinational successor: next larger word with the same popcount (Gosper's hack, no divider).
module weight_gen_next
  import weight_gen_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic [DATA_WIDTH-1:0] x,
  output logic [DATA_WIDTH-1:0] next_word
);

  logic [DATA_WIDTH-1:0] low_bit;
  logic [DATA_WIDTH-1:0] ripple;
  logic [MAX_W-1:0]      x_ext;

  always_comb begin
    x_ext                   = '0;
    x_ext[DATA_WIDTH-1:0]   = x;
    low_bit                 = x & (-x);
    ripple                  = x + low_bit;
    // Bits that fell off the carried run are re-packed at the bottom.
    next_word = ripple | (((x ^ ripple) >> 2) >> ctz_w(x_ext, DATA_WIDTH));
  end

endmodule

// File: rtl/weight_word_gen.sv
// Emits every DATA_WIDTH-bit word with exactly k ones, ascending, over valid/ready.
// Optional idx output (word index) enabled by defining WEIGHT_GEN_COUNT_EN.
module weight_word_gen
  import weight_gen_pkg::*;
#(
  parameter  int DATA_WIDTH = 16,
  localparam int KW         = $clog2(DATA_WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_valid,
  output logic                  start_ready,
  input  logic [KW-1:0]         k,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_last,
  output logic                  busy
`ifdef WEIGHT_GEN_COUNT_EN
  ,
  output logic [DATA_WIDTH-1:0] idx
`endif
);

  state_t                state, state_n;
  logic [KW-1:0]         k_eff;
  logic [KW-1:0]         k_sat;
  logic [DATA_WIDTH-1:0] next_word;
  logic [DATA_WIDTH-1:0] last_word;

  assign k_sat     = (k > KW'(DATA_WIDTH)) ? KW'(DATA_WIDTH) : k;
  // Final word has all k_eff ones packed at the top.
  assign last_word = ~({DATA_WIDTH{1'b1}} >> k_eff);
  assign dout_last = (state == RUN) && ((k_eff == '0) || (dout == last_word));

  weight_gen_next #(.DATA_WIDTH(DATA_WIDTH)) u_next (
    .x         (dout),
    .next_word (next_word)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n     = state;
    start_ready = 1'b0;
    dout_valid  = 1'b0;
    busy        = 1'b0;
    case (state)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) state_n = RUN;
      end
      RUN: begin
        dout_valid = 1'b1;
        busy       = 1'b1;
        if (dout_ready && dout_last) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout  <= '0;
      k_eff <= '0;
    end else if (state == IDLE && start_valid) begin
      k_eff <= k_sat;
      dout  <= ~({DATA_WIDTH{1'b1}} << k_sat);
    end else if (state == RUN && dout_ready) begin
      dout <= dout_last ? '0 : next_word;
    end
  end

`ifdef WEIGHT_GEN_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx <= '0;
    end else if (state == RUN && dout_ready) begin
      idx <= dout_last ? '0 : idx + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_weight_word_gen.sv
// Directed bench for weight_word_gen: a 4-bit instance for hand vectors, a 16-bit one for k=8.
module tb_weight_word_gen;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // 4-bit instance
  logic       sv4, sr4, dv4, dr4, dl4, busy4;
  logic [2:0] k4;
  logic [3:0] d4;
  // 16-bit instance
  logic        sv16, sr16, dv16, dr16, dl16, busy16;
  logic [4:0]  k16;
  logic [15:0] d16;
`ifdef WEIGHT_GEN_COUNT_EN
  logic [3:0]  idx4;
  logic [15:0] idx16;
`endif

  weight_word_gen #(.DATA_WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .start_valid(sv4), .start_ready(sr4), .k(k4),
    .dout_valid(dv4), .dout_ready(dr4), .dout(d4), .dout_last(dl4), .busy(busy4)
`ifdef WEIGHT_GEN_COUNT_EN
    , .idx(idx4)
`endif
  );

  weight_word_gen #(.DATA_WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .start_valid(sv16), .start_ready(sr16), .k(k16),
    .dout_valid(dv16), .dout_ready(dr16), .dout(d16), .dout_last(dl16), .busy(busy16)
`ifdef WEIGHT_GEN_COUNT_EN
    , .idx(idx16)
`endif
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle4(input string tag);
    chk({tag, "_valid"}, 32'(dv4), 0);
    chk({tag, "_ready"}, 32'(sr4), 1);
    chk({tag, "_busy"},  32'(busy4), 0);
    chk({tag, "_last"},  32'(dl4), 0);
    chk({tag, "_dout"},  32'(d4), 0);
`ifdef WEIGHT_GEN_COUNT_EN
    chk({tag, "_idx"},   32'(idx4), 0);
`endif
  endtask

  // Checks one presented word on the 4-bit instance.
  task automatic chk_word4(input string tag, input logic [3:0] w, input logic last, input int i);
    chk({tag, "_valid"}, 32'(dv4), 1);
    chk({tag, "_dout"},  32'(d4), 32'(w));
    chk({tag, "_last"},  32'(dl4), 32'(last));
`ifdef WEIGHT_GEN_COUNT_EN
    chk({tag, "_idx"},   32'(idx4), 32'(i));
`else
    if (i < 0) $display("unused index");
`endif
  endtask

  logic [3:0] seq2 [6];
  logic [3:0] seq1 [4];
  logic [3:0] seq3 [4];

  initial begin
    logic [15:0] prev, held;
    logic        was_stalled, got_last;
    int          count;

    seq2 = '{4'b0011, 4'b0101, 4'b0110, 4'b1001, 4'b1010, 4'b1100};
    seq1 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    seq3 = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

    reset = 1'b1;
    sv4 = 0; k4 = 0; dr4 = 1;
    sv16 = 0; k16 = 0; dr16 = 0;
    repeat (2) @(negedge clk);
    chk_idle4("reset");
    chk("reset_ready16", 32'(sr16), 1);
    reset = 1'b0;
    @(negedge clk);

    // k=2 full sequence, ready held high
    sv4 = 1; k4 = 2;
    @(negedge clk);
    sv4 = 0;
    chk("k2_start_ready", 32'(sr4), 0);
    chk("k2_busy", 32'(busy4), 1);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      chk_word4("k2", seq2[i], i == 5, i);
    end
    @(negedge clk);
    chk_idle4("k2_after");

    // Single-word sequences: k=0, k=4, saturating k=7
    sv4 = 1; k4 = 0;
    @(negedge clk);
    sv4 = 0;
    chk_word4("k0", 4'b0000, 1, 0);
    @(negedge clk);
    chk_idle4("k0_after");
    sv4 = 1; k4 = 4;
    @(negedge clk);
    sv4 = 0;
    chk_word4("k4", 4'b1111, 1, 0);
    @(negedge clk);
    chk("k4_after_valid", 32'(dv4), 0);
    sv4 = 1; k4 = 7;
    @(negedge clk);
    sv4 = 0;
    chk_word4("k7", 4'b1111, 1, 0);
    @(negedge clk);
    chk_idle4("k7_after");

    // Backpressure on the second word
    sv4 = 1; k4 = 2;
    @(negedge clk);
    sv4 = 0;
    chk_word4("bp0", seq2[0], 0, 0);
    @(negedge clk);
    chk_word4("bp1", seq2[1], 0, 1);
    dr4 = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_word4("bp_hold", seq2[1], 0, 1);
    end
    dr4 = 1;
    for (int i = 2; i < 6; i++) begin
      @(negedge clk);
      chk_word4("bp_resume", seq2[i], i == 5, i);
    end
    @(negedge clk);
    chk_idle4("bp_after");

    // Asynchronous reset on the third word
    sv4 = 1; k4 = 2;
    @(negedge clk);
    sv4 = 0;
    @(negedge clk);
    @(negedge clk);
    chk_word4("rst_pre", seq2[2], 0, 2);
    reset = 1'b1;
    #1;
    chk_idle4("rst_async");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_idle4("rst_after");
    sv4 = 1; k4 = 1;
    @(negedge clk);
    sv4 = 0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      chk_word4("k1", seq1[i], i == 3, i);
    end
    @(negedge clk);
    chk_idle4("k1_after");

    // Request held during RUN: k changes but is ignored until the sequence ends
    sv4 = 1; k4 = 1;
    @(negedge clk);
    k4 = 3;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      chk("hold_start_ready", 32'(sr4), 0);
      chk_word4("hold_k1", seq1[i], i == 3, i);
    end
    @(negedge clk);
    chk("hold_gap_valid", 32'(dv4), 0);
    chk("hold_gap_ready", 32'(sr4), 1);
    @(negedge clk);
    sv4 = 0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      chk_word4("hold_k3", seq3[i], i == 3, i);
    end
    @(negedge clk);
    chk_idle4("hold_after");

    // 16-bit, k=8, random ready: C(16,8)=12870 words
    sv16 = 1; k16 = 8;
    @(negedge clk);
    sv16 = 0;
    count = 0; prev = '0; held = '0; was_stalled = 0; got_last = 0;
    for (int cyc = 0; cyc < 60000 && !got_last; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (was_stalled) chk("w16_hold", 32'(d16), 32'(held));
      if (!dv16) begin
        chk("w16_valid", 32'(dv16), 1);
        break;
      end
      dr16 = ($urandom_range(3) != 0);
      if (dr16) begin
        chk("w16_popcount", 32'($countones(d16)), 8);
        if (count > 0) chk("w16_ascending", 32'(d16 > prev), 1);
        prev = d16;
        count++;
        if (dl16) begin
          got_last = 1;
          chk("w16_last_word", 32'(d16), 32'h0000_FF00);
`ifdef WEIGHT_GEN_COUNT_EN
          chk("w16_last_idx", 32'(idx16), 12869);
`endif
        end
        was_stalled = 0;
      end else begin
        held = d16;
        was_stalled = 1;
      end
    end
    chk("w16_finished", 32'(got_last), 1);
    chk("w16_count", 32'(count), 12870);
    @(negedge clk);
    dr16 = 0;
    chk("w16_after_valid", 32'(dv16), 0);
    chk("w16_after_busy", 32'(busy16), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
